// File: rtl/seq_rec_pkg.sv
// Shared defaults and types for the multi-channel run-length recognizer.
package seq_rec_pkg;
  localparam int NUM_CH_DEF  = 4;
  localparam int RUN_LEN_DEF = 2;
  localparam int CNT_W_DEF   = 8;
  // Wide enough for the largest supported run length (15).
  localparam int RUN_W       = 4;

  typedef logic [$clog2(NUM_CH_DEF)-1:0] ch_idx_t;

  typedef struct packed {
    logic             last_bit;
    logic             primed;
    logic [RUN_W-1:0] run;
  } ctx_t;
endpackage

// File: rtl/seq_rec_sched_core.sv
// Combinational run-length step: next context and detect flag for one sample.
module seq_rec_core
  import seq_rec_pkg::*;
#(
  parameter int RUN_LEN = RUN_LEN_DEF
) (
  input  ctx_t ctx,
  input  logic sample,
  output ctx_t next_ctx,
  output logic detect
);
  always_comb begin
    next_ctx          = ctx;
    next_ctx.last_bit = sample;
    next_ctx.primed   = 1'b1;
    if (!ctx.primed || sample != ctx.last_bit) begin
      next_ctx.run = RUN_W'(1);
    end else if (ctx.run < RUN_W'(RUN_LEN)) begin
      next_ctx.run = ctx.run + RUN_W'(1);
    end
    // A saturated run keeps detecting on every further equal bit.
    detect = ctx.primed && (next_ctx.run == RUN_W'(RUN_LEN));
  end
endmodule

// File: rtl/seq_rec_sched.sv
// Round-robin scheduler sharing one recognizer across NUM_CH serial channels.
// Hit counters are built only when SEQ_REC_SCHED_CNT_EN is defined.
module seq_rec_sched
  import seq_rec_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int RUN_LEN = RUN_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         ch_valid,
  input  logic [NUM_CH-1:0]         ch_bit,
  input  logic [NUM_CH-1:0]         ch_clear,
  output logic [NUM_CH-1:0]         ch_ready,
  output logic                      det_valid,
  output logic [$clog2(NUM_CH)-1:0] det_ch,
  output logic [CNT_W-1:0]          det_count
);
  localparam int IDX_W = $clog2(NUM_CH);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] sel;
  logic             found;
  logic             accept;
  logic             hit;
  ctx_t             ctx [NUM_CH];
  ctx_t             core_next;
  logic             core_detect;

  always_comb begin
    int idx;
    ch_ready = '0;
    sel      = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (!found && ch_valid[idx]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
    if (found && !reset) ch_ready[sel] = 1'b1;
  end

  assign accept = found && !reset;
  // A clear on the granted channel consumes the sample and suppresses its detection.
  assign hit    = accept && core_detect && !ch_clear[sel];

  seq_rec_core #(.RUN_LEN(RUN_LEN)) u_core (
    .ctx      (ctx[sel]),
    .sample   (ch_bit[sel]),
    .next_ctx (core_next),
    .detect   (core_detect)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr       <= '0;
      det_valid <= 1'b0;
      det_ch    <= '0;
      for (int i = 0; i < NUM_CH; i++) ctx[i] <= '0;
    end else begin
      det_valid <= hit;
      if (accept) begin
        ptr    <= (sel == IDX_W'(NUM_CH - 1)) ? '0 : sel + IDX_W'(1);
        det_ch <= sel;
        ctx[sel] <= core_next;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_clear[i]) ctx[i] <= '0;
      end
    end
  end

`ifdef SEQ_REC_SCHED_CNT_EN
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [CNT_W-1:0] cnt_next;

  assign cnt_next = (&cnt[sel]) ? cnt[sel] : cnt[sel] + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      det_count <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      if (hit) begin
        cnt[sel]  <= cnt_next;
        det_count <= cnt_next;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_clear[i]) cnt[i] <= '0;
      end
    end
  end
`else
  assign det_count = '0;
`endif
endmodule

// File: tb/tb_seq_rec_sched.sv
// Table-driven check of grants, detections and counters for seq_rec_sched (4 ch, run 2, 2-bit counters).
module tb_seq_rec_sched;
  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] ch_valid, ch_bit, ch_clear, ch_ready;
  logic       det_valid;
  logic [1:0] det_ch, det_count;

  always #5 clock = ~clock;

  seq_rec_sched #(.NUM_CH(4), .RUN_LEN(2), .CNT_W(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .ch_valid  (ch_valid),
    .ch_bit    (ch_bit),
    .ch_clear  (ch_clear),
    .ch_ready  (ch_ready),
    .det_valid (det_valid),
    .det_ch    (det_ch),
    .det_count (det_count)
  );

  typedef struct {
    logic       rst;
    logic [3:0] vld, bits, clr, rdy;
    logic       chk, dv;
    logic [1:0] ch, cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void add(logic rst, logic [3:0] vld, logic [3:0] bits, logic [3:0] clr,
                              logic [3:0] rdy, logic chk, logic dv, logic [1:0] ch, logic [1:0] cnt);
    vec_t v;
    v.rst = rst; v.vld = vld; v.bits = bits; v.clr = clr; v.rdy = rdy;
    v.chk = chk; v.dv = dv; v.ch = ch; v.cnt = cnt;
    tbl.push_back(v);
  endfunction

  // Counters only exist in the counting build; otherwise det_count is tied to zero.
  function automatic logic [1:0] exp_cnt(logic [1:0] c);
`ifdef SEQ_REC_SCHED_CNT_EN
    return c;
`else
    return 2'd0 & c;
`endif
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic [3:0] vld, logic [3:0] bits, logic [3:0] clr);
    @(negedge clock);
    reset = rst; ch_valid = vld; ch_bit = bits; ch_clear = clr;
    #1;
  endtask

  initial begin
    reset = 1'b1; ch_valid = '0; ch_bit = '0; ch_clear = '0;

    //   rst vld      bits     clr      rdy      chk  dv   ch     cnt
    add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1, 0, 2'd0, 2'd0);  // reset blocks grants
    add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1, 0, 2'd0, 2'd0);
    // ch0 bits 1,1,0,0,0
    add(0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 2'd0, 2'd0);
    add(0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 2'd0, 2'd0);
    add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 1, 2'd0, 2'd1);
    add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, 2'd0, 2'd0);
    add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 1, 2'd0, 2'd2);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 2'd0, 2'd3);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 2'd0, 2'd0);
    // reset, then all channels request: round-robin 0,1,2,3,0,1,2,3
    add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1, 0, 2'd0, 2'd0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1, 0, 2'd0, 2'd0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 1, 0, 2'd0, 2'd0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1, 0, 2'd0, 2'd0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 1, 0, 2'd0, 2'd0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1, 0, 2'd0, 2'd0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 1, 1, 2'd0, 2'd1);
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1, 1, 2'd1, 2'd1);
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 1, 1, 2'd2, 2'd1);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 2'd3, 2'd1);
    // ch2 gets 1,1 while ch1 is cleared mid-stream
    add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1, 0, 2'd0, 2'd0);
    add(0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1, 0, 2'd0, 2'd0);
    add(0, 4'b0100, 4'b0100, 4'b0010, 4'b0100, 1, 0, 2'd0, 2'd0);
    add(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1, 0, 2'd0, 2'd0);
    add(0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1, 1, 2'd2, 2'd1);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 2'd0, 2'd0);
    // clear on ch0 coincides with its matching 2nd bit
    add(0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 2'd0, 2'd0);
    add(0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 1, 0, 2'd0, 2'd0);
    add(0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 2'd0, 2'd0);
    add(0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 2'd0, 2'd0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 2'd0, 2'd1);
    // ch3 six 1s: counter saturates at 3
    for (int k = 0; k < 6; k++) begin
      add(0, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1, (k >= 2), 2'd3,
          (k == 2) ? 2'd1 : (k == 3) ? 2'd2 : 2'd3);
    end
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 2'd3, 2'd3);
    // ch1 detecting accept, then reset before its pulse can be used
    add(0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1, 0, 2'd0, 2'd0);
    add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 2'd0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1, 0, 2'd0, 2'd0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 2'd0, 2'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].bits, tbl[i].clr);
      check($sformatf("ready[%0d]", i), 8'(ch_ready), 8'(tbl[i].rdy));
      if (tbl[i].chk) begin
        check($sformatf("det_valid[%0d]", i), 8'(det_valid), 8'(tbl[i].dv));
        if (tbl[i].dv) begin
          check($sformatf("det_ch[%0d]", i), 8'(det_ch), 8'(tbl[i].ch));
          check($sformatf("det_count[%0d]", i), 8'(det_count), 8'(exp_cnt(tbl[i].cnt)));
        end
      end
    end

    // Clearing ch1 as it is granted must not disturb the pointer or ch0's primed context.
    drive(0, 4'b0011, 4'b0000, 4'b0010);
    check("iso_grant_ch1", 8'(ch_ready), 8'b0010);
    drive(0, 4'b0011, 4'b0000, 4'b0000);
    check("iso_grant_ch0", 8'(ch_ready), 8'b0001);
    check("iso_no_det_ch1", 8'(det_valid), 8'd0);
    drive(0, 4'b0000, 4'b0000, 4'b0000);
    check("iso_det_ch0", 8'(det_valid), 8'd1);
    check("iso_det_ch0_idx", 8'(det_ch), 8'd0);
    check("iso_det_ch0_cnt", 8'(det_count), 8'(exp_cnt(2'd1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
